// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage memory access unit: FSM states,
// byte-enable constants and writeback-source codes.
// Latency: n/a (definitions only). Backpressure: n/a.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  // Writeback source select codes carried through EX/MEM -> MEM/WB.
  localparam logic [1:0] REG_WR_SRC_ALU = 2'd0;
  localparam logic [1:0] REG_WR_SRC_MEM = 2'd1;
  localparam logic [1:0] REG_WR_SRC_PC4 = 2'd2;
  localparam logic [1:0] REG_WR_SRC_IMM = 2'd3;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the MEM stage (master) and memory (slave).
// Latency: n/a (wires only). Backpressure: request side valid/ready; the
// response side has no ready, the master must accept rsp_valid when waiting.
// Ports: req_valid/req_ready/req_we/req_addr/req_wdata/req_be, rsp_valid/rsp_rdata.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed byte lane and sign-extends it,
// or passes the full word through. Latency: combinational. Backpressure: none.
// Ports: lane (addr[1:0]), lb_w (1=word), rdata (raw bus word), data (result).
module mem_load_align (
  input  logic [1:0]  lane,
  input  logic        lb_w,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = rdata[7:0];
    case (lane)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
    data = lb_w ? rdata : {{24{sel_byte[7]}}, sel_byte};
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage responder: one bus transaction per load/store, registered MEM/WB fields.
// Latency: non-mem op 1 cycle; store 3, load 4 cycles with zero-wait bus.
// Backpressure: stall_o holds IF..EX/MEM while a memory op is in flight.
// Ports: clk, rst_n (sync, active-low); ex_* EX/MEM inputs; bus (master
// modport of mem_access_unit_if); wb_* MEM/WB registers; stall_o; misalign_o.
// Option: MISALIGN_TRAP_EN makes misaligned word accesses trap (no bus
// request, 1-cycle misalign_o pulse) instead of silently clearing addr[1:0].
module mem_access_unit
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_mem_rd_i,
  input  logic                  ex_mem_wr_i,
  input  logic                  ex_sb_w_i,
  input  logic                  ex_lb_w_i,
  input  logic [ADDR_WIDTH-1:0] ex_addr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  ex_reg_write_i,
  input  logic [NUM_WIDTH-1:0]  ex_wr_num_i,
  input  logic [1:0]            ex_reg_wr_src_i,
  output logic                  stall_o,
  mem_access_unit_if.master     bus,
  output logic [DATA_WIDTH-1:0] wb_rdata_o,
  output logic [ADDR_WIDTH-1:0] wb_alu_o,
  output logic [NUM_WIDTH-1:0]  wb_wr_num_o,
  output logic                  wb_reg_write_o,
  output logic [1:0]            wb_reg_wr_src_o,
  output logic                  misalign_o
);

  // Everything about the memory op that must survive until DONE.
  typedef struct packed {
    logic                  we;
    logic                  word;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  reg_write;
    logic [NUM_WIDTH-1:0]  wr_num;
    logic [1:0]            wr_src;
  } mem_op_t;

  mem_state_e            state_q, state_d;
  mem_op_t               op_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rsp_aligned;
  logic                  memop;
  logic                  ex_word;
  logic                  trap;

  assign memop   = ex_mem_rd_i | ex_mem_wr_i;
  // A read wins when both rd and wr are set, so the load size applies.
  assign ex_word = ex_mem_rd_i ? ex_lb_w_i : ex_sb_w_i;

`ifdef MISALIGN_TRAP_EN
  assign trap = memop & ex_word & (ex_addr_i[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    stall_o       = 1'b0;
    bus.req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop && !trap) begin
          stall_o = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall_o       = 1'b1;
        bus.req_valid = 1'b1;
        // Stores are posted: no response phase.
        if (bus.req_ready) state_d = op_q.we ? DONE : WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (bus.rsp_valid) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields come only from captured state so they stay stable under backpressure.
  assign bus.req_we    = op_q.we;
  assign bus.req_addr  = op_q.word ? {op_q.addr[ADDR_WIDTH-1:2], 2'b00} : op_q.addr;
  assign bus.req_wdata = op_q.word ? op_q.wdata : {4{op_q.wdata[7:0]}};
  assign bus.req_be    = op_q.word ? BE_WORD : (BE_BYTE0 << op_q.addr[1:0]);

  mem_load_align u_load_align (
    .lane  (op_q.addr[1:0]),
    .lb_w  (op_q.word),
    .rdata (bus.rsp_rdata),
    .data  (rsp_aligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      op_q            <= '0;
      rdata_q         <= '0;
      wb_rdata_o      <= '0;
      wb_alu_o        <= '0;
      wb_wr_num_o     <= '0;
      wb_reg_write_o  <= 1'b0;
      wb_reg_wr_src_o <= 2'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (trap) begin
            wb_reg_write_o <= 1'b0;
          end else if (memop) begin
            op_q.we        <= ex_mem_wr_i & ~ex_mem_rd_i;
            op_q.word      <= ex_word;
            op_q.addr      <= ex_addr_i;
            op_q.wdata     <= ex_wdata_i;
            op_q.reg_write <= ex_reg_write_i;
            op_q.wr_num    <= ex_wr_num_i;
            op_q.wr_src    <= ex_reg_wr_src_i;
            wb_reg_write_o <= 1'b0;
          end else begin
            wb_alu_o        <= ex_addr_i;
            wb_wr_num_o     <= ex_wr_num_i;
            wb_reg_write_o  <= ex_reg_write_i;
            wb_reg_wr_src_o <= ex_reg_wr_src_i;
          end
        end
        REQ: begin
          wb_reg_write_o <= 1'b0;
        end
        WAIT: begin
          wb_reg_write_o <= 1'b0;
          if (bus.rsp_valid) rdata_q <= rsp_aligned;
        end
        DONE: begin
          wb_rdata_o      <= rdata_q;
          wb_alu_o        <= op_q.addr;
          wb_wr_num_o     <= op_q.wr_num;
          wb_reg_write_o  <= op_q.reg_write;
          wb_reg_wr_src_o <= op_q.wr_src;
        end
        default: wb_reg_write_o <= 1'b0;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= (state_q == IDLE) && trap;
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit: directed cases, then random ops
// against a byte-addressed reference memory, then reset during a load wait.
// Bus-side memory model is independent of the reference model.
module tb_mem_access_unit;
  import rv32_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_rd = 0, ex_wr = 0, ex_sb_w = 0, ex_lb_w = 0, ex_reg_write = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0;
  logic [4:0]  ex_wr_num = 0;
  logic [1:0]  ex_src = 0;
  logic        stall, misalign, wb_reg_write;
  logic [31:0] wb_rdata, wb_alu;
  logic [4:0]  wb_wr_num;
  logic [1:0]  wb_src;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_rd_i(ex_rd), .ex_mem_wr_i(ex_wr), .ex_sb_w_i(ex_sb_w), .ex_lb_w_i(ex_lb_w),
    .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata), .ex_reg_write_i(ex_reg_write),
    .ex_wr_num_i(ex_wr_num), .ex_reg_wr_src_i(ex_src),
    .stall_o(stall), .bus(bus.master),
    .wb_rdata_o(wb_rdata), .wb_alu_o(wb_alu), .wb_wr_num_o(wb_wr_num),
    .wb_reg_write_o(wb_reg_write), .wb_reg_wr_src_o(wb_src), .misalign_o(misalign)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_exp_t;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  num;
    logic        rw;
    logic [1:0]  src;
    logic        is_load;
    logic [31:0] rdata;
    logic        trap;
  } wb_exp_t;

  bus_exp_t    bus_q[$];
  wb_exp_t     wb_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] slv_mem[int];

  int n_cmp = 0;
  int n_bad = 0;
  bit driving = 0;
  bit cfg_rand = 0;
  int cfg_rdy = 0;
  bit cfg_hold = 0;
  bit late_rsp = 0;
  bit slave_pend = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int k);
    return (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int k = int'(a >> 2);
    if (!ref_mem.exists(k)) ref_mem[k] = init_word(k);
    return ref_mem[k];
  endfunction

  function automatic logic [31:0] slv_word(input int k);
    if (!slv_mem.exists(k)) slv_mem[k] = init_word(k);
    return slv_mem[k];
  endfunction

  // Reference semantics: a byte load returns the addressed byte as a signed value.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic word);
    logic [31:0] w = ref_word(a);
    int sh = 8 * int'(a % 4);
    int b;
    if (word) return w;
    b = int'((w >> sh) & 32'hFF);
    if (b >= 128) b = b - 256;
    return 32'(b);
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic word, input logic [31:0] d);
    logic [31:0] w = ref_word(a);
    int sh = 8 * int'(a % 4);
    logic [31:0] mask = 32'hFF << sh;
    if (word) ref_mem[int'(a >> 2)] = d;
    else      ref_mem[int'(a >> 2)] = (w & ~mask) | ((d & 32'hFF) << sh);
  endfunction

  function automatic void push_bus(input logic rd, input logic wr, input logic word,
                                   input logic [31:0] a, input logic [31:0] d);
    bus_exp_t e;
    e.we    = wr && !rd;
    e.addr  = word ? (a & ~32'd3) : a;
    e.be    = word ? 4'hF : 4'(1 << (a % 4));
    e.wdata = word ? d : (d & 32'hFF) * 32'h0101_0101;
    bus_q.push_back(e);
  endfunction

  // Presents one EX/MEM instruction and holds it until the DUT lets it advance.
  task automatic issue(input logic rd, input logic wr, input logic sb_w, input logic lb_w,
                       input logic [31:0] a, input logic [31:0] d, input logic rw,
                       input logic [4:0] num, input logic [1:0] src, output int cycles);
    wb_exp_t w;
    logic word = rd ? lb_w : sb_w;
    logic trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (rd || wr) && word && (a % 4 != 0);
`endif
    @(posedge clk); #1;
    ex_rd = rd; ex_wr = wr; ex_sb_w = sb_w; ex_lb_w = lb_w; ex_addr = a; ex_wdata = d;
    ex_reg_write = rw; ex_wr_num = num; ex_src = src; driving = 1;
    w.alu = a; w.num = num; w.rw = trap ? 1'b0 : rw; w.src = src;
    w.is_load = rd && !trap; w.trap = trap; w.rdata = 32'h0;
    if ((rd || wr) && !trap) push_bus(rd, wr, word, a, d);
    if (rd && !trap) w.rdata = model_load(a, word);
    else if (wr && !trap) model_store(a, word, d);
    wb_q.push_back(w);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (stall && cycles < 200);
    if (stall) begin
      n_cmp++; n_bad++;
      $display("FAIL retire_timeout: stall still 1 after %0d cycles, required 0", cycles);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    ex_rd = 0; ex_wr = 0; ex_reg_write = 0; driving = 0;
  endtask

  // WB monitor: the cycle after stall_o=0 with an instruction presented, wb_* reflect it.
  initial begin : wb_mon
    bit retire;
    wb_exp_t w;
    retire = 0;
    forever begin
      @(negedge clk);
      if (retire) begin
        if (wb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wb_unexpected: retire with empty queue");
        end else begin
          w = wb_q.pop_front();
          check("wb_reg_write", 32'(wb_reg_write), 32'(w.rw));
          check("misalign", 32'(misalign), 32'(w.trap));
          if (!w.trap) begin
            check("wb_alu", wb_alu, w.alu);
            check("wb_wr_num", 32'(wb_wr_num), 32'(w.num));
            check("wb_src", 32'(wb_src), 32'(w.src));
          end
          if (w.is_load) check("wb_rdata", wb_rdata, w.rdata);
        end
      end
      retire = driving && !stall && rst_n;
    end
  end

  // Bus slave + request scoreboard.
  initial begin : slave
    bit first;
    int rdy_wait, rsp_wait, k;
    logic [31:0] pend_addr, wv;
    bus_exp_t e, cur;
    first = 1; rdy_wait = 0; rsp_wait = 0; pend_addr = 0;
    bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_rdata = 0;
    forever begin
      @(negedge clk);
      bus.req_ready = 0;
      bus.rsp_valid = 0;
      bus.rsp_rdata = $urandom;
      if (!rst_n) begin
        slave_pend = 0; first = 1;
        continue;
      end
      if (slave_pend) begin
        if (!cfg_hold) begin
          if (rsp_wait == 0) begin
            bus.rsp_valid = 1;
            bus.rsp_rdata = slv_word(int'(pend_addr >> 2));
            slave_pend = 0;
          end else rsp_wait--;
        end
      end else if (late_rsp) begin
        bus.rsp_valid = 1; bus.rsp_rdata = 32'hBAD0_BAD0; late_rsp = 0;
      end else if (cfg_rand && $urandom_range(0, 3) == 0) begin
        bus.rsp_valid = 1;  // stray response, must be ignored
      end
      if (bus.req_valid) begin
        check("req_stall", 32'(stall), 32'd1);
        if (first) begin
          cur.we = bus.req_we; cur.addr = bus.req_addr; cur.wdata = bus.req_wdata; cur.be = bus.req_be;
          if (bus_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL bus_unexpected: request addr %08h with empty queue", bus.req_addr);
          end else begin
            e = bus_q.pop_front();
            check("bus_we", 32'(cur.we), 32'(e.we));
            check("bus_addr", cur.addr, e.addr);
            check("bus_be", 32'(cur.be), 32'(e.be));
            if (e.we) check("bus_wdata", cur.wdata, e.wdata);
          end
          rdy_wait = cfg_rand ? int'($urandom_range(0, 3)) : cfg_rdy;
          first = 0;
        end else begin
          check("stable_addr", bus.req_addr, cur.addr);
          check("stable_we", 32'(bus.req_we), 32'(cur.we));
          check("stable_be", 32'(bus.req_be), 32'(cur.be));
          check("stable_wdata", bus.req_wdata, cur.wdata);
        end
        if (rdy_wait == 0) begin
          bus.req_ready = 1;
          first = 1;
          if (bus.req_we) begin
            k = int'(bus.req_addr >> 2);
            wv = slv_word(k);
            for (int i = 0; i < 4; i++)
              if (bus.req_be[i]) wv[8*i +: 8] = bus.req_wdata[8*i +: 8];
            slv_mem[k] = wv;
          end else begin
            slave_pend = 1;
            pend_addr = bus.req_addr;
            rsp_wait = cfg_rand ? int'($urandom_range(0, 2)) : 0;
          end
        end else rdy_wait--;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    logic rd, wr;
    int kind;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 0);
    check("rst_valid", 32'(bus.req_valid), 0);
    check("rst_wb_rdata", wb_rdata, 0);
    check("rst_wb_alu", wb_alu, 0);
    check("rst_wb_num", 32'(wb_wr_num), 0);
    check("rst_wb_rw", 32'(wb_reg_write), 0);
    check("rst_wb_src", 32'(wb_src), 0);
    check("rst_misalign", 32'(misalign), 0);
    @(posedge clk); #1 rst_n = 1;

    // Directed, zero-wait bus.
    issue(0, 0, 0, 0, 32'h1234, 0, 1, 5'd5, REG_WR_SRC_ALU, cyc);
    check("lat_nonmem", cyc, 1);
    issue(0, 1, 1, 0, 32'h100, 32'hDEAD_BEEF, 0, 5'd0, REG_WR_SRC_ALU, cyc);
    check("lat_store", cyc, 3);
    issue(0, 1, 1, 0, 32'h200, 32'h80FF_FFFF, 0, 5'd0, REG_WR_SRC_ALU, cyc);
    issue(1, 0, 0, 0, 32'h203, 0, 1, 5'd7, REG_WR_SRC_MEM, cyc);
    check("lat_load", cyc, 4);
    issue(0, 1, 1, 0, 32'h200, 32'h7F00_0000, 0, 5'd0, REG_WR_SRC_ALU, cyc);
    issue(1, 0, 0, 0, 32'h203, 0, 1, 5'd8, REG_WR_SRC_MEM, cyc);
    issue(0, 1, 0, 0, 32'h002, 32'h0000_00A5, 0, 5'd0, REG_WR_SRC_ALU, cyc);
    issue(1, 0, 0, 1, 32'h000, 0, 1, 5'd9, REG_WR_SRC_MEM, cyc);
    cfg_rdy = 3;
    issue(0, 1, 1, 0, 32'h100, 32'hDEAD_BEEF, 0, 5'd0, REG_WR_SRC_ALU, cyc);
    check("lat_store_bp3", cyc, 6);
    cfg_rdy = 0;
    issue(1, 0, 0, 1, 32'h102, 0, 1, 5'd10, REG_WR_SRC_MEM, cyc);
    issue(1, 1, 1, 0, 32'h101, 32'h1111_1111, 1, 5'd11, REG_WR_SRC_MEM, cyc);
    issue(0, 0, 0, 0, 32'hCAFE_0000, 0, 1, 5'd12, REG_WR_SRC_PC4, cyc);
    check("lat_nonmem2", cyc, 1);

    // Random traffic with backpressure, response delay and stray responses.
    cfg_rand = 1;
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 2));
      rd = (kind == 1); wr = (kind == 2);
      if ($urandom_range(0, 9) == 0) begin rd = 1; wr = 1; end
      a = (rd || wr) ? 32'h100 + 32'($urandom_range(0, 63)) : $urandom;
      issue(rd, wr, 1'($urandom), 1'($urandom), a, $urandom, 1'($urandom),
            5'($urandom), rd ? REG_WR_SRC_MEM : 2'($urandom), cyc);
    end
    cfg_rand = 0;
    go_idle();

    // Reset while waiting for a load response; the late response must be ignored.
    cfg_hold = 1;
    @(posedge clk); #1;
    ex_rd = 1; ex_wr = 0; ex_lb_w = 1; ex_addr = 32'h120; ex_reg_write = 1; ex_wr_num = 5'd3;
    push_bus(1, 0, 1, 32'h120, 0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!slave_pend && cyc < 20);
    check("rst_test_handshake", 32'(slave_pend), 1);
    @(posedge clk); #1;
    rst_n = 0; ex_rd = 0; ex_reg_write = 0;
    @(posedge clk); #1;
    rst_n = 1; cfg_hold = 0; late_rsp = 1;
    @(negedge clk);
    check("rst_wait_valid", 32'(bus.req_valid), 0);
    check("rst_wait_stall", 32'(stall), 0);
    check("rst_wait_rw", 32'(wb_reg_write), 0);
    @(negedge clk);
    @(negedge clk);
    check("late_rsp_valid", 32'(bus.req_valid), 0);
    check("late_rsp_stall", 32'(stall), 0);
    check("late_rsp_rw", 32'(wb_reg_write), 0);
    issue(1, 0, 0, 1, 32'h100, 0, 1, 5'd4, REG_WR_SRC_MEM, cyc);
    go_idle();
    repeat (3) @(negedge clk);
    check("bus_q_empty", 32'(bus_q.size()), 0);
    check("wb_q_empty", 32'(wb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
